// File: rtl/branch_resolve_unit_if.sv
// Decode/execute-side bundle for the branch resolve unit: decode fields in,
// fetch redirect, memory-stage link data and status out.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             validD;
  logic [XLEN-1:0]  pcD;
  logic [XLEN-1:0]  pcplus4D;
  logic [XLEN-1:0]  immextD;
  logic [XLEN-1:0]  rs1D;
  logic [XLEN-1:0]  rs2D;
  logic [2:0]       funct3D;
  logic             branchD;
  logic             jumpD;
  logic             jalrD;
  logic             stallE;
  logic             pcsrcE;
  logic [XLEN-1:0]  pctargetE;
  logic             flushD;
  logic             validM;
  logic [XLEN-1:0]  linkM;
  logic             link_weM;
  logic [CNT_W-1:0] taken_cnt;
  logic             misalign_o;
  logic             illegal_o;

  modport master (
    output validD, pcD, pcplus4D, immextD, rs1D, rs2D, funct3D,
           branchD, jumpD, jalrD, stallE,
    input  pcsrcE, pctargetE, flushD, validM, linkM, link_weM,
           taken_cnt, misalign_o, illegal_o
  );

  modport slave (
    input  validD, pcD, pcplus4D, immextD, rs1D, rs2D, funct3D,
           branchD, jumpD, jalrD, stallE,
    output pcsrcE, pctargetE, flushD, validM, linkM, link_weM,
           taken_cnt, misalign_o, illegal_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: ID/EX register, RV32I condition and target
// evaluation, fetch redirect/flush, EX/M link register and redirect statistics.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            valid_e_q, valid_e_d;
  logic [XLEN-1:0] pc_e_q, pc_e_d;
  logic [XLEN-1:0] pcplus4_e_q, pcplus4_e_d;
  logic [XLEN-1:0] imm_e_q, imm_e_d;
  logic [XLEN-1:0] rs1_e_q, rs1_e_d;
  logic [XLEN-1:0] rs2_e_q, rs2_e_d;
  logic [2:0]      funct3_e_q, funct3_e_d;
  logic            branch_e_q, branch_e_d;
  logic            jump_e_q, jump_e_d;
  logic            jalr_e_q, jalr_e_d;

  logic            valid_m_q, valid_m_d;
  logic [XLEN-1:0] link_m_q, link_m_d;
  logic            link_we_m_q, link_we_m_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic            misalign_q, misalign_d;
  logic            illegal_q, illegal_d;

  logic            cond;
  logic            pcsrc;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;

  always_comb begin
    cond = 1'b0;
    case (funct3_e_q)
      3'b000:  cond = (rs1_e_q == rs2_e_q);
      3'b001:  cond = (rs1_e_q != rs2_e_q);
      3'b100:  cond = ($signed(rs1_e_q) <  $signed(rs2_e_q));
      3'b101:  cond = ($signed(rs1_e_q) >= $signed(rs2_e_q));
      3'b110:  cond = (rs1_e_q <  rs2_e_q);
      3'b111:  cond = (rs1_e_q >= rs2_e_q);
      default: cond = 1'b0;
    endcase
  end

  // Redirect comes only from registered E state; the target reads zero when idle.
  always_comb begin
    pcsrc      = valid_e_q & ~bus.stallE & (jump_e_q | jalr_e_q | (branch_e_q & cond));
    jalr_sum   = rs1_e_q + imm_e_q;
    target_raw = jalr_e_q ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_e_q + imm_e_q);
    target     = pcsrc ? target_raw : '0;
  end

  always_comb begin
    valid_e_d   = valid_e_q;
    pc_e_d      = pc_e_q;
    pcplus4_e_d = pcplus4_e_q;
    imm_e_d     = imm_e_q;
    rs1_e_d     = rs1_e_q;
    rs2_e_d     = rs2_e_q;
    funct3_e_d  = funct3_e_q;
    branch_e_d  = branch_e_q;
    jump_e_d    = jump_e_q;
    jalr_e_d    = jalr_e_q;
    if (!bus.stallE) begin
      pc_e_d      = bus.pcD;
      pcplus4_e_d = bus.pcplus4D;
      imm_e_d     = bus.immextD;
      rs1_e_d     = bus.rs1D;
      rs2_e_d     = bus.rs2D;
      funct3_e_d  = bus.funct3D;
      // A redirect squashes the instruction in decode by loading a bubble.
      valid_e_d   = pcsrc ? 1'b0 : bus.validD;
      branch_e_d  = pcsrc ? 1'b0 : bus.branchD;
      jump_e_d    = pcsrc ? 1'b0 : bus.jumpD;
      jalr_e_d    = pcsrc ? 1'b0 : bus.jalrD;
    end
  end

  always_comb begin
    valid_m_d   = 1'b0;
    link_we_m_d = 1'b0;
    link_m_d    = link_m_q;
    if (!bus.stallE) begin
      valid_m_d   = valid_e_q;
      link_we_m_d = valid_e_q & (jump_e_q | jalr_e_q);
      link_m_d    = pcplus4_e_q;
    end
    taken_cnt_d = (pcsrc && taken_cnt_q != CNT_MAX) ? taken_cnt_q + 1'b1 : taken_cnt_q;
    misalign_d  = misalign_q | (pcsrc & (target[1:0] != 2'b00));
    illegal_d   = illegal_q | (valid_e_q & branch_e_q & ~bus.stallE &
                               (funct3_e_q[2:1] == 2'b01));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e_q   <= 1'b0;
      pc_e_q      <= '0;
      pcplus4_e_q <= '0;
      imm_e_q     <= '0;
      rs1_e_q     <= '0;
      rs2_e_q     <= '0;
      funct3_e_q  <= '0;
      branch_e_q  <= 1'b0;
      jump_e_q    <= 1'b0;
      jalr_e_q    <= 1'b0;
      valid_m_q   <= 1'b0;
      link_m_q    <= '0;
      link_we_m_q <= 1'b0;
      taken_cnt_q <= '0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_e_q   <= valid_e_d;
      pc_e_q      <= pc_e_d;
      pcplus4_e_q <= pcplus4_e_d;
      imm_e_q     <= imm_e_d;
      rs1_e_q     <= rs1_e_d;
      rs2_e_q     <= rs2_e_d;
      funct3_e_q  <= funct3_e_d;
      branch_e_q  <= branch_e_d;
      jump_e_q    <= jump_e_d;
      jalr_e_q    <= jalr_e_d;
      valid_m_q   <= valid_m_d;
      link_m_q    <= link_m_d;
      link_we_m_q <= link_we_m_d;
      taken_cnt_q <= taken_cnt_d;
      misalign_q  <= misalign_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.pcsrcE     = pcsrc;
  assign bus.pctargetE  = target;
  assign bus.flushD     = pcsrc;
  assign bus.validM     = valid_m_q;
  assign bus.linkM      = link_m_q;
  assign bus.link_weM   = link_we_m_q;
  assign bus.taken_cnt  = taken_cnt_q;
  assign bus.misalign_o = misalign_q;
  assign bus.illegal_o  = illegal_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a vector table of single branches/jumps
// plus hand-written JALR, stall, illegal, saturation and async-reset sequences.
module tb_branch_resolve_unit;
  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  int   expCnt;

  branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bus ();
  branch_resolve_unit_if #(.XLEN(32), .CNT_W(2))  busSmall ();

  branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(2)) dutSmall (
    .clk (clk),
    .rst (rst),
    .bus (busSmall.slave)
  );

  assign busSmall.validD   = bus.validD;
  assign busSmall.pcD      = bus.pcD;
  assign busSmall.pcplus4D = bus.pcplus4D;
  assign busSmall.immextD  = bus.immextD;
  assign busSmall.rs1D     = bus.rs1D;
  assign busSmall.rs2D     = bus.rs2D;
  assign busSmall.funct3D  = bus.funct3D;
  assign busSmall.branchD  = bus.branchD;
  assign busSmall.jumpD    = bus.jumpD;
  assign busSmall.jalrD    = bus.jalrD;
  assign busSmall.stallE   = bus.stallE;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  f3;
    logic        br;
    logic        jmp;
    logic        jr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic        expTaken;
    logic [31:0] expTarget;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one instruction in decode, clock it into E, settle just past the edge.
  task automatic applyStimulus(input logic vld, input logic [2:0] f3, input logic br,
                               input logic jmp, input logic jr, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] a,
                               input logic [31:0] b);
    bus.validD   = vld;
    bus.funct3D  = f3;
    bus.branchD  = br;
    bus.jumpD    = jmp;
    bus.jalrD    = jr;
    bus.pcD      = pc;
    bus.pcplus4D = pc + 32'd4;
    bus.immextD  = imm;
    bus.rs1D     = a;
    bus.rs2D     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] smallCnt(input int n);
    return (n > 3) ? 32'd3 : n;
  endfunction

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    expCnt      = 0;
    bus.stallE  = 1'b0;
    rst         = 1'b0;

    vecs[0] = '{3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h5, 32'h5, 1'b1, 32'h120};
    vecs[1] = '{3'b001, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h5, 32'h5, 1'b0, 32'h0};
    vecs[2] = '{3'b100, 1'b1, 1'b0, 1'b0, 32'h200, 32'h10, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h210};
    vecs[3] = '{3'b110, 1'b1, 1'b0, 1'b0, 32'h200, 32'h10, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0};
    vecs[4] = '{3'b101, 1'b1, 1'b0, 1'b0, 32'h300, 32'hFFFFFFF0, 32'h1, 32'hFFFFFFFF, 1'b1, 32'h2F0};
    vecs[5] = '{3'b111, 1'b1, 1'b0, 1'b0, 32'h300, 32'hFFFFFFF0, 32'h1, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[6] = '{3'b000, 1'b0, 1'b1, 1'b0, 32'h400, 32'h8, 32'h0, 32'h0, 1'b1, 32'h408};
    vecs[7] = '{3'b000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h20, 32'h7, 32'h7, 1'b1, 32'h10};
    vecs[8] = '{3'b100, 1'b1, 1'b0, 1'b0, 32'h500, 32'h4, 32'h3, 32'h3, 1'b0, 32'h0};
    vecs[9] = '{3'b101, 1'b1, 1'b0, 1'b0, 32'h500, 32'h4, 32'h3, 32'h3, 1'b1, 32'h504};

    idleCycle();
    idleCycle();
    checkOutput("reset_pcsrcE", {31'b0, bus.pcsrcE}, 32'h0);
    checkOutput("reset_pctargetE", bus.pctargetE, 32'h0);
    checkOutput("reset_flushD", {31'b0, bus.flushD}, 32'h0);
    checkOutput("reset_validM", {31'b0, bus.validM}, 32'h0);
    checkOutput("reset_linkM", bus.linkM, 32'h0);
    checkOutput("reset_link_weM", {31'b0, bus.link_weM}, 32'h0);
    checkOutput("reset_taken_cnt", {16'b0, bus.taken_cnt}, 32'h0);
    checkOutput("reset_flags", {30'b0, bus.misalign_o, bus.illegal_o}, 32'h0);
    rst = 1'b1;
    idleCycle();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].f3, vecs[i].br, vecs[i].jmp, vecs[i].jr,
                    vecs[i].pc, vecs[i].imm, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d_pcsrcE", i), {31'b0, bus.pcsrcE}, {31'b0, vecs[i].expTaken});
      checkOutput($sformatf("vec%0d_flushD", i), {31'b0, bus.flushD}, {31'b0, vecs[i].expTaken});
      checkOutput($sformatf("vec%0d_pctargetE", i), bus.pctargetE, vecs[i].expTarget);
      if (vecs[i].expTaken) expCnt++;
      idleCycle();
      checkOutput($sformatf("vec%0d_bubble_pcsrcE", i), {31'b0, bus.pcsrcE}, 32'h0);
      checkOutput($sformatf("vec%0d_taken_cnt", i), {16'b0, bus.taken_cnt}, expCnt);
      checkOutput($sformatf("vec%0d_small_cnt", i), {30'b0, busSmall.taken_cnt}, smallCnt(expCnt));
    end
    checkOutput("vectors_misalign", {31'b0, bus.misalign_o}, 32'h0);
    checkOutput("vectors_illegal", {31'b0, bus.illegal_o}, 32'h0);

    // JALR with an odd sum and a misaligned result; link data lands in M.
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h40, 32'h4, 32'h203, 32'h0);
    checkOutput("jalr_pcsrcE", {31'b0, bus.pcsrcE}, 32'h1);
    checkOutput("jalr_pctargetE", bus.pctargetE, 32'h206);
    expCnt++;
    idleCycle();
    checkOutput("jalr_misalign", {31'b0, bus.misalign_o}, 32'h1);
    checkOutput("jalr_link_weM", {31'b0, bus.link_weM}, 32'h1);
    checkOutput("jalr_validM", {31'b0, bus.validM}, 32'h1);
    checkOutput("jalr_linkM", bus.linkM, 32'h44);
    checkOutput("jalr_pcsrc_after", {31'b0, bus.pcsrcE}, 32'h0);
    idleCycle();
    checkOutput("jalr_link_we_clear", {31'b0, bus.link_weM}, 32'h0);

    // Taken BNE held by a 3-cycle stall while decode shows a different jump.
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 32'h600, 32'h40, 32'h1, 32'h2);
    bus.stallE = 1'b1;
    #1;
    checkOutput("stall_start_pcsrcE", {31'b0, bus.pcsrcE}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 32'h800, 32'h100, 32'h0, 32'h0);
      checkOutput($sformatf("stall%0d_pcsrcE", c), {31'b0, bus.pcsrcE}, 32'h0);
      checkOutput($sformatf("stall%0d_validM", c), {31'b0, bus.validM}, 32'h0);
      checkOutput($sformatf("stall%0d_taken_cnt", c), {16'b0, bus.taken_cnt}, expCnt);
    end
    bus.stallE = 1'b0;
    bus.validD = 1'b0;
    #1;
    checkOutput("stall_release_pcsrcE", {31'b0, bus.pcsrcE}, 32'h1);
    checkOutput("stall_release_target", bus.pctargetE, 32'h640);
    expCnt++;
    idleCycle();
    checkOutput("stall_after_pcsrcE", {31'b0, bus.pcsrcE}, 32'h0);
    checkOutput("stall_taken_cnt", {16'b0, bus.taken_cnt}, expCnt);
    idleCycle();
    checkOutput("stall_no_repeat", {31'b0, bus.pcsrcE}, 32'h0);

    // Reserved funct3 010 never redirects but raises the sticky illegal flag.
    applyStimulus(1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 32'h700, 32'h8, 32'h9, 32'h9);
    checkOutput("illegal_pcsrcE", {31'b0, bus.pcsrcE}, 32'h0);
    idleCycle();
    checkOutput("illegal_flag", {31'b0, bus.illegal_o}, 32'h1);
    idleCycle();
    checkOutput("illegal_sticky", {31'b0, bus.illegal_o}, 32'h1);
    checkOutput("illegal_taken_cnt", {16'b0, bus.taken_cnt}, expCnt);
    checkOutput("sat_small_cnt", {30'b0, busSmall.taken_cnt}, 32'h3);

    // Asynchronous reset in the middle of a redirect cycle.
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 32'h900, 32'h10, 32'h0, 32'h0);
    checkOutput("prerst_pcsrcE", {31'b0, bus.pcsrcE}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_pcsrcE", {31'b0, bus.pcsrcE}, 32'h0);
    checkOutput("arst_pctargetE", bus.pctargetE, 32'h0);
    checkOutput("arst_validM", {31'b0, bus.validM}, 32'h0);
    checkOutput("arst_taken_cnt", {16'b0, bus.taken_cnt}, 32'h0);
    checkOutput("arst_flags", {30'b0, bus.misalign_o, bus.illegal_o}, 32'h0);
    checkOutput("arst_small_cnt", {30'b0, busSmall.taken_cnt}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
